uart_rx_fifo: RTL and testbench

UART receiver with a byte FIFO, the receive counterpart of the existing `uart_tx`. It deserialises 8N1 frames from the board `Uart_RX` pin, validates the start and stop bits, and buffers good bytes for the consumer. Its read handshake (`data_ready` / `read_ack`) matches the SPI slave's, so the top level can bridge UART to SPI with the same echo state machine.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with first-word fall-through read
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Full push+pop reuses the slot being read; the head is consumed this cycle.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a byte FIFO with data_ready/read_ack handshake
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [UART_DATA_BITS-1:0]     data,
    output logic                          data_ready,
    input  logic                          read_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF         = CLKS_PER_BIT / 2 - 1;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(UART_DATA_BITS - 1);

    rx_state_t                state_q;
    logic                     rx_meta_q;
    logic                     rx_s_q;
    logic                     rx_prev_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [IDX_W-1:0]         bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                     framing_error_q;
    logic                     overrun_q;
    logic                     push;
    logic                     fifo_full;
    logic                     fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // A good stop bit writes straight into the FIFO so the byte is visible next cycle.
    assign push = (state_q == STOP) && (bit_cnt_q == LAST_C) && rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            bit_cnt_q       <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        bit_cnt_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_cnt_q == HALF_C) begin
                        if (!rx_s_q) begin
                            bit_cnt_q <= '0;
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_cnt_q == LAST_C) begin
                        shift_q[bit_idx_q] <= rx_s_q;
                        bit_cnt_q          <= '0;
                        bit_idx_q          <= bit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        if (bit_idx_q == TOP_IDX) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_cnt_q == LAST_C) begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            framing_error_q <= 1'b1;
                            state_q         <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A pop in the push cycle frees the slot, so only an unread full FIFO drops the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && fifo_full && !read_ack;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift_q),
        .pop   (read_ack),
        .rdata (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_ready    = !fifo_empty;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int CPB   = 16;
    // Pin edge after posedge p gives t0=p+2; stop sample at t0+HALF+1+9*CPB; byte visible one edge later.
    localparam int PUSH_LAT = 2 + (CPB / 2 - 1) + 1 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_ready;
    logic       read_ack;
    logic [2:0] fifo_count;
    logic       framing_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int p;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0;
    int ov0;
    logic ra_edge = 1'b0;

    typedef struct {
        int         at;
        bit         good;
        logic [7:0] b;
    } evt_t;

    evt_t       ev[$];
    logic [7:0] mq[$];

    uart_rx_fifo #(
        .CLOCK_FREQUENCY (16_000_000),
        .BAUD_RATE       (1_000_000),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data          (data),
        .data_ready    (data_ready),
        .read_ack      (read_ack),
        .fifo_count    (fifo_count),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ra_edge <= read_ack;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_one();
        read_ack = 1'b1;
        wait_n(1);
        read_ack = 1'b0;
    endtask

    // Drives one 8N1 frame and tells the model what must happen at the stop sample + 1.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        evt_t e;
        e.at   = cyc + PUSH_LAT;
        e.good = stop_ok;
        e.b    = b;
        ev.push_back(e);
        rx = 1'b0;
        wait_n(CPB);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            wait_n(CPB);
        end
        rx = stop_ok;
        wait_n(CPB);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            fe_cnt += int'(framing_error);
            ov_cnt += int'(overrun);
        end
    end

    always @(negedge clk) begin : model
        int n;
        bit popped;
        bit e_fe;
        bit e_ov;
        if (rst) begin
            mq.delete();
            ev.delete();
        end else begin
            n      = mq.size();
            popped = 1'b0;
            e_fe   = 1'b0;
            e_ov   = 1'b0;
            if (ra_edge && n > 0) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
            while (ev.size() > 0 && ev[0].at <= cyc) begin
                if (ev[0].good) begin
                    if (n < DEPTH || popped) mq.push_back(ev[0].b);
                    else e_ov = 1'b1;
                end else begin
                    e_fe = 1'b1;
                end
                void'(ev.pop_front());
            end
            chk("m_ready", 32'(data_ready), 32'(mq.size() > 0));
            chk("m_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_fe", 32'(framing_error), 32'(e_fe));
            chk("m_ov", 32'(overrun), 32'(e_ov));
            if (mq.size() > 0) chk("m_data", 32'(data), 32'(mq[0]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b;
        rst      = 1'b1;
        rx       = 1'b1;
        read_ack = 1'b0;
        wait_n(3);
        chk("rst_ready", 32'(data_ready), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_fe", 32'(framing_error), 0);
        chk("rst_ov", 32'(overrun), 0);
        rst = 1'b0;
        wait_n(5);

        p = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cyc(p + 154);
                chk("a5_pre_ready", 32'(data_ready), 0);
                wait_cyc(p + 155);
                chk("a5_ready", 32'(data_ready), 1);
                chk("a5_data", 32'(data), 32'h A5);
            end
        join
        read_one();
        chk("a5_pop_ready", 32'(data_ready), 0);
        chk("a5_pop_count", 32'(fifo_count), 0);

        fe0 = fe_cnt;
        rx  = 1'b0;
        wait_n(4);
        rx = 1'b1;
        wait_n(8);
        send_frame(8'h5A, 1'b1);
        wait_n(2);
        chk("glitch_fe", 32'(fe_cnt - fe0), 0);
        chk("glitch_count", 32'(fifo_count), 1);
        chk("glitch_data", 32'(data), 32'h5A);
        read_one();

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_n(40 * CPB);
        rx = 1'b1;
        wait_n(20);
        chk("brk_fe_pulses", 32'(fe_cnt - fe0), 1);
        chk("brk_count", 32'(fifo_count), 0);
        send_frame(8'h11, 1'b1);
        wait_n(2);
        chk("brk_next_count", 32'(fifo_count), 1);
        chk("brk_next_data", 32'(data), 32'h11);
        read_one();

        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        wait_n(2);
        chk("ovr_count", 32'(fifo_count), 4);
        chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_read", 32'(data), 32'(i));
            read_one();
        end
        chk("ovr_empty", 32'(data_ready), 0);

        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1);
        p = cyc;
        fork
            send_frame(8'h25, 1'b1);
            begin
                wait_cyc(p + 154);
                read_ack = 1'b1;
                wait_cyc(p + 155);
                read_ack = 1'b0;
                chk("fullpop_count_now", 32'(fifo_count), 4);
            end
        join
        wait_n(2);
        chk("fullpop_ov", 32'(ov_cnt - ov0), 0);
        chk("fullpop_count", 32'(fifo_count), 4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h22 + 8'(i);
            chk("fullpop_read", 32'(data), 32'(exp_b));
            read_one();
        end

        send_frame(8'h99, 1'b1);
        wait_n(2);
        chk("pre_rst_count", 32'(fifo_count), 1);
        rx = 1'b0;
        wait_n(CPB);
        rx = 1'b0;
        wait_n(CPB);
        rx = 1'b1;
        wait_n(CPB);
        rx = 1'b1;
        wait_n(CPB / 2);
        fe0 = fe_cnt;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_ready", 32'(data_ready), 0);
        wait_n(3);
        rst = 1'b0;
        wait_n(30);
        send_frame(8'h42, 1'b1);
        wait_n(2);
        chk("midrst_fe", 32'(fe_cnt - fe0), 0);
        chk("midrst_next_count", 32'(fifo_count), 1);
        chk("midrst_next_data", 32'(data), 32'h42);
        read_one();
        wait_n(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
